csr_access_unit: RTL and testbench
==================================

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 Parameter REG_W, default 32, SHALL set the data width of all CSR data ports.
REQ-002 Parameter RO_CHECK, default 1, SHALL enable illegal-write detection for read-only addresses (addr[11:10]==2'b11) when 1.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate a Zicsr request is presented.
REQ-006 req_ready  output  1  SHALL indicate the unit can accept a request.
REQ-007 req_op  input  3  SHALL carry the instruction funct3.
REQ-008 req_addr  input  12  SHALL carry the CSR address.
REQ-009 req_src  input  REG_W  SHALL carry the rs1 value, or the zero-extended zimm for immediate ops.
REQ-010 req_rs1_zero  input  1  SHALL flag rs1==x0, or zimm==0 for immediate ops.
REQ-011 req_rd_zero  input  1  SHALL flag rd==x0.
REQ-012 resp_valid  output  1  SHALL indicate a completed response.
REQ-013 resp_ready  input  1  SHALL indicate the consumer accepts the response.
REQ-014 resp_rdata  output  REG_W  SHALL carry the old CSR value for writeback to rd.
REQ-015 resp_illegal  output  1  SHALL flag an illegal-instruction result.
REQ-016 csr_addr  output  12  SHALL drive the CSR file address.
REQ-017 csr_wen  output  1  SHALL drive the CSR file write enable.
REQ-018 csr_wdata  output  REG_W  SHALL drive the CSR file write data.
REQ-019 csr_rdata  input  REG_W  SHALL be the combinational CSR file read data for csr_addr.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, READ, WRITE and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; on req_valid&&req_ready (cycle T), op, addr, src, rs1_zero and rd_zero SHALL be captured and the FSM SHALL enter READ.
REQ-022 In READ (T+1), csr_addr SHALL equal the captured addr, and csr_rdata SHALL be registered as old_value.
REQ-023 Op decoding SHALL be: 001/101 RW, new=src; 010/110 RS, new=old|src; 011/111 RC, new=old&~src.
REQ-024 Write-needed SHALL be 1 for RW ops and SHALL be !rs1_zero for RS and RC ops.
REQ-025 Illegal SHALL be set when op is 000 or 100, or when RO_CHECK==1 && addr[11:10]==2'b11 && write-needed.
REQ-026 From READ, the FSM SHALL go to WRITE if write-needed && !illegal, and to RESP otherwise.
REQ-027 In WRITE (T+2), csr_wen SHALL be 1 for exactly one cycle, with csr_wdata=new and csr_addr=captured addr; the FSM SHALL then enter RESP.
REQ-028 csr_wen SHALL be 0 in every state other than WRITE, and it SHALL never be asserted for an illegal request.
REQ-029 In RESP, resp_valid SHALL be 1 and all response outputs SHALL be held stable until resp_ready; on the handshake the FSM SHALL return to IDLE.
REQ-030 Back-to-back requests are permitted; the next request SHALL be accepted one cycle after the response handshake, in IDLE.
REQ-031 Latency: resp_valid SHALL first assert at T+3 for a write and at T+2 for no-write or illegal.
REQ-032 resp_rdata SHALL be old_value, or 0 when illegal; resp_illegal SHALL be 0 for legal requests.
REQ-033 The CSR read SHALL be performed even when rd_zero=1, because the CSR file reads have no side effects; resp_rdata is then don't-care for the consumer.
REQ-034 csr_addr SHALL be 0 in IDLE and SHALL hold the captured addr in READ, WRITE and RESP.

Reset
REQ-035 On reset low, the FSM SHALL enter IDLE asynchronously, including mid-operation, and any in-flight request SHALL be dropped with no csr_wen.
REQ-036 Reset values SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_wen=0, csr_wdata=0, csr_addr=0.

Structure
REQ-037 Package csr_pkg SHALL hold the state enum, the op funct3 constants and the CSR address constants (MISA 12'h301, MCYCLE 12'hB00, MCYCLEH 12'hB80, MINSTRET 12'hB02, MINSTRETH 12'hB82, MVENDORID 12'hF11, MARCHID 12'hF12), shared with the CSR file.
REQ-038 Sub-module csr_alu (combinational: op, old, src -> new, write-needed, illegal) SHALL hold all op arithmetic.

Verification
REQ-039 CSRRS addr 12'h301, rs1_zero=1, CSR file returns 32'h40000010 -> resp at T+2, rdata 32'h40000010, csr_wen never 1.
REQ-040 CSRRW addr 12'h340, src 32'hDEADBEEF, old 32'h12345678 -> csr_wen at T+2 only, wdata 32'hDEADBEEF, rdata 32'h12345678.
REQ-041 CSRRC src 32'h0000000F, old 32'h000000FF -> wdata 32'h000000F0, rdata 32'h000000FF.
REQ-042 CSRRW addr 12'hF11 -> resp_illegal=1, rdata 0, no csr_wen; op 3'b100 -> resp_illegal=1.
REQ-043 resp_ready held low 5 cycles -> resp_valid and rdata held stable, req_ready=0 throughout; the next request is accepted after the handshake.
REQ-044 reset asserted during READ of a CSRRW -> next cycle IDLE, req_ready=1, no csr_wen observed.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: FSM states, Zicsr funct3 encodings and CSR addresses shared with the CSR file
package csr_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;
  localparam logic [11:0] MISA      = 12'h301;
  localparam logic [11:0] MCYCLE    = 12'hB00;
  localparam logic [11:0] MCYCLEH   = 12'hB80;
  localparam logic [11:0] MINSTRET  = 12'hB02;
  localparam logic [11:0] MINSTRETH = 12'hB82;
  localparam logic [11:0] MVENDORID = 12'hF11;
  localparam logic [11:0] MARCHID   = 12'hF12;
endpackage

// File: rtl/csr_alu.sv
// csr_alu: Zicsr op arithmetic, write-needed and illegal decode
module csr_alu import csr_pkg::*; #(
  parameter int REG_W    = 32,
  parameter int RO_CHECK = 1
) (
  input  logic [2:0]       op,
  input  logic [11:0]      addr,
  input  logic             rs1_zero,
  input  logic [REG_W-1:0] old,
  input  logic [REG_W-1:0] src,
  output logic [REG_W-1:0] new_value,
  output logic             write_needed,
  output logic             illegal
);
  logic is_rw, is_rs, is_rc;
  assign is_rw = op == CSRRW || op == CSRRWI;
  assign is_rs = op == CSRRS || op == CSRRSI;
  assign is_rc = op == CSRRC || op == CSRRCI;
  assign new_value    = is_rw ? src : is_rs ? (old | src) : (old & ~src);
  assign write_needed = is_rw || ((is_rs || is_rc) && !rs1_zero);
  // read-only space is addr[11:10]==2'b11; only an actual write to it traps
  assign illegal = !(is_rw || is_rs || is_rc) ||
                   (RO_CHECK == 1 && addr[11:10] == 2'b11 && write_needed);
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr request as read, optional write, then response
module csr_access_unit import csr_pkg::*; #(
  parameter int REG_W    = 32,
  parameter int RO_CHECK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [11:0]      req_addr,
  input  logic [REG_W-1:0] req_src,
  input  logic             req_rs1_zero,
  input  logic             req_rd_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [REG_W-1:0] resp_rdata,
  output logic             resp_illegal,
  output logic [11:0]      csr_addr,
  output logic             csr_wen,
  output logic [REG_W-1:0] csr_wdata,
  input  logic [REG_W-1:0] csr_rdata
);
  state_t state, next;
  logic [2:0] op_q;
  logic [11:0] addr_q;
  logic [REG_W-1:0] src_q, old_q, new_value;
  logic rs1_zero_q, rd_zero_q, write_needed, illegal;
  logic unused_rd_zero;
  assign unused_rd_zero = rd_zero_q;

  csr_alu #(.REG_W(REG_W), .RO_CHECK(RO_CHECK)) u_alu (
    .op(op_q), .addr(addr_q), .rs1_zero(rs1_zero_q), .old(old_q), .src(src_q),
    .new_value(new_value), .write_needed(write_needed), .illegal(illegal)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_illegal = 1'b0;
    csr_wen = 1'b0;
    csr_wdata = '0;
    csr_addr = addr_q;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        csr_addr = '0;
        next = req_valid ? READ : IDLE;
      end
      READ: next = (write_needed && !illegal) ? WRITE : RESP;
      WRITE: begin
        csr_wen = 1'b1;
        csr_wdata = new_value;
        next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = illegal ? '0 : old_q;
        resp_illegal = illegal;
        next = resp_ready ? IDLE : RESP;
      end
      default: next = IDLE;
    endcase
  end

  // the read happens even for rd==x0: CSR reads here have no side effects
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= '0;
      addr_q <= '0;
      src_q <= '0;
      rs1_zero_q <= 1'b0;
      rd_zero_q <= 1'b0;
      old_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q <= req_op;
        addr_q <= req_addr;
        src_q <= req_src;
        rs1_zero_q <= req_rs1_zero;
        rd_zero_q <= req_rd_zero;
      end
      if (state == READ) old_q <= csr_rdata;
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: random and directed Zicsr requests checked against a behavioural model
module tb_csr_access_unit;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_rs1_zero = 0, req_rd_zero = 0;
  logic [2:0] req_op = 0;
  logic [11:0] req_addr = 0, csr_addr;
  logic [31:0] req_src = 0, resp_rdata, csr_wdata, csr_rdata;
  logic resp_valid, resp_ready = 0, resp_illegal, csr_wen;
  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];
  logic [11:0] addr_set [8] = '{12'h301, 12'h340, 12'hB00, 12'hB82, 12'hF11, 12'hF12, 12'hC00, 12'h7C0};
  int n_checks = 0, n_fail = 0, cyc = 0, wen_cnt = 0, wen_cyc = 0;
  logic [31:0] wen_data;
  logic [11:0] wen_addr;

  csr_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_src(req_src),
    .req_rs1_zero(req_rs1_zero), .req_rd_zero(req_rd_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal), .csr_addr(csr_addr), .csr_wen(csr_wen),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;
  assign csr_rdata = csr_mem[csr_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_wen) csr_mem[csr_addr] <= csr_wdata;
  end
  always @(negedge clk) if (csr_wen) begin
    wen_cnt++;
    wen_cyc = cyc;
    wen_data = csr_wdata;
    wen_addr = csr_addr;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic rs1z, input logic rdz, input int hold);
    logic [31:0] old_v, new_v, exp_rdata;
    logic wr, ill;
    int lat, t0;
    old_v = ref_mem[addr];
    ill = 0;
    case (op)
      3'b001, 3'b101: begin wr = 1; new_v = src; end
      3'b010, 3'b110: begin wr = !rs1z; new_v = old_v | src; end
      3'b011, 3'b111: begin wr = !rs1z; new_v = old_v & ~src; end
      default: begin wr = 0; new_v = old_v; ill = 1; end
    endcase
    if (addr >= 12'hC00 && wr) ill = 1;
    if (ill) wr = 0;
    exp_rdata = ill ? 32'h0 : old_v;
    wen_cnt = 0;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = addr; req_src = src;
    req_rs1_zero = rs1z; req_rd_zero = rdz;
    t0 = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, wr ? 3 : 2);
    check("rdata", resp_rdata, exp_rdata);
    check("illegal", resp_illegal, ill);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 0;
    check("back_idle", req_ready, 1);
    check("idle_csr_addr", csr_addr, 0);
    check("wen_count", wen_cnt, wr ? 1 : 0);
    if (wr) begin
      check("wen_cycle", wen_cyc - t0, 2);
      check("wdata", wen_data, new_v);
      check("waddr", wen_addr, addr);
      ref_mem[addr] = new_v;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      ref_mem[i] = csr_mem[i];
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_illegal", resp_illegal, 0);
    check("rst_csr_wen", csr_wen, 0);
    check("rst_csr_wdata", csr_wdata, 0);
    check("rst_csr_addr", csr_addr, 0);
    rst_n = 1;
    @(negedge clk);
    csr_mem[12'h301] = 32'h40000010; ref_mem[12'h301] = 32'h40000010;
    run_txn(3'b010, 12'h301, 32'h0, 1, 0, 0);
    csr_mem[12'h340] = 32'h12345678; ref_mem[12'h340] = 32'h12345678;
    run_txn(3'b001, 12'h340, 32'hDEADBEEF, 0, 0, 0);
    check("mem_340", csr_mem[12'h340], 32'hDEADBEEF);
    csr_mem[12'h341] = 32'h000000FF; ref_mem[12'h341] = 32'h000000FF;
    run_txn(3'b011, 12'h341, 32'h0000000F, 0, 0, 0);
    check("mem_341", csr_mem[12'h341], 32'h000000F0);
    run_txn(3'b001, 12'hF11, 32'h5, 0, 0, 0);
    run_txn(3'b100, 12'h340, 32'h5, 0, 0, 0);
    run_txn(3'b110, 12'hF12, 32'h0, 1, 1, 5);
    // reset while the READ of a CSRRW is in progress
    req_valid = 1; req_op = 3'b001; req_addr = 12'h340; req_src = 32'hCAFEF00D;
    req_rs1_zero = 0; wen_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    rst_n = 0;
    #1 check("async_rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1;
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_valid", resp_valid, 0);
    @(negedge clk);
    check("rst_mid_wen", wen_cnt, 0);
    check("rst_mid_mem", csr_mem[12'h340], ref_mem[12'h340]);
    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      logic [31:0] src;
      logic rs1z;
      op = 3'($urandom_range(0, 7));
      rs1z = $urandom_range(0, 3) == 0;
      src = rs1z ? 32'h0 : (op[2] ? 32'($urandom_range(1, 31)) : $urandom);
      run_txn(op, addr_set[$urandom_range(0, 7)], src, rs1z, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) check("final_mem", csr_mem[addr_set[i]], ref_mem[addr_set[i]]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
